// File: rtl/data_mem_responder.sv
// Multi-cycle 64-bit data memory behind a request/response handshake. One request in flight;
// access happens LATENCY edges after acceptance, and the response is held until resp_ready.
module data_mem_responder #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic        req_write,
    input  logic        req_byte,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  count;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        write_q;
    logic        byte_q;
    logic [63:0] rdata_q;
    logic        err_q;
    logic [63:0] mem [WORDS];

    logic        fire;
    logic [63:0] a_addr;
    logic [63:0] a_wdata;
    logic        a_write;
    logic        a_byte;
    logic [IW-1:0] widx;
    logic [2:0]  lane;
    logic        in_range;
    logic [63:0] word;
    logic [7:0]  bsel;
    logic [63:0] load_data;

    // With zero latency the access happens on the accepting edge, so it must use the live inputs.
    always_comb begin
        a_addr  = addr_q;
        a_wdata = wdata_q;
        a_write = write_q;
        a_byte  = byte_q;
        if (state == IDLE) begin
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_write = req_write;
            a_byte  = req_byte;
        end
    end

    assign fire      = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                       ((state == WAIT) && (count == 4'd1));
    assign in_range  = (a_addr[63:3] < 61'(WORDS));
    assign widx      = a_addr[IW+2:3];
    assign lane      = a_addr[2:0];
    assign word      = mem[widx];
    assign bsel      = word[{lane, 3'b000} +: 8];
    assign load_data = a_byte ? {{56{bsel[7]}}, bsel} : word;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (fire && a_write && in_range) begin
            if (a_byte) begin
                mem[widx][{lane, 3'b000} +: 8] <= a_wdata[7:0];
            end else begin
                mem[widx] <= a_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        write_q <= req_write;
                        byte_q  <= req_byte;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state   <= IDLE;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (fire) begin
                rdata_q <= (in_range && !a_write) ? load_data : 64'd0;
                err_q   <= !in_range;
            end
        end
    end
endmodule
